lsu_mmio: RTL and testbench

Parametrised RV32I/RV64I load/store unit sitting between the execute stage and the data memory. It accepts one load/store request at a time. It generates byte-lane enables and performs sign/zero extension according to the load/store funct3 encodings. Stores and loads to a bank of memory-mapped output-port registers are serviced locally without a memory access. Misaligned accesses and illegal encodings are flagged instead of being issued to memory.

---
 rtl/lsu_mmio.sv | 254 +++++++++++++++++++++++++
 tb/tb_lsu_mmio.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio.sv
// RV32I/RV64I load/store unit with local memory-mapped output ports; PORT/ERR respond 1 cycle after accept,
// MEM responds 1 cycle after mem_ack (2 min). One request in flight: req_ready only in IDLE; resp_valid has no backpressure.
module lsu_mmio #(
    parameter int          XLEN         = 32,
    parameter int          NUM_OUTPORTS = 2,
    parameter logic [31:0] OUTPORT_BASE = 32'h0000fffc
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [2:0]                   req_funct3,
    input  logic [XLEN-1:0]              req_addr,
    input  logic [XLEN-1:0]              req_wdata,
    output logic                         resp_valid,
    output logic [XLEN-1:0]              resp_rdata,
    output logic                         resp_err,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [XLEN-1:0]              mem_addr,
    output logic [XLEN/8-1:0]            mem_be,
    output logic [XLEN-1:0]              mem_wdata,
    input  logic                         mem_ack,
    input  logic [XLEN-1:0]              mem_rdata,
    output logic [NUM_OUTPORTS*XLEN-1:0] outport,
    output logic [NUM_OUTPORTS-1:0]      outport_wr
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic                                   we_q, we_d;
    logic [2:0]                             f3_q, f3_d;
    logic [OFFW-1:0]                        off_q, off_d;
    logic [XLEN-1:0]                        addr_q, addr_d;
    logic [NB-1:0]                          be_q, be_d;
    logic [XLEN-1:0]                        wdata_q, wdata_d;
    logic [XLEN-1:0]                        rdata_q, rdata_d;
    logic                                   err_q, err_d;
    logic [NUM_OUTPORTS-1:0][XLEN-1:0]      outport_q, outport_d;
    logic [NUM_OUTPORTS-1:0]                outport_wr_q, outport_wr_d;

    logic [XLEN-1:0]         addr_al;
    logic [OFFW-1:0]         off_in;
    logic [1:0]              size_in;
    logic                    f3_ok;
    logic                    misaligned;
    logic                    req_err;
    logic                    port_hit;
    logic [NUM_OUTPORTS-1:0] port_match;
    logic [NB-1:0]           be_in;
    logic [XLEN-1:0]         wdata_rep;
    logic [XLEN-1:0]         port_rd;

    // Right-justify the addressed lane(s), then sign- or zero-extend by funct3.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] data,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [2:0]      f3);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = data >> {off, 3'b000};
        case (f3)
            3'b000:  res = XLEN'($signed(sh[7:0]));
            3'b001:  res = XLEN'($signed(sh[15:0]));
            3'b010:  res = XLEN'($signed(sh[31:0]));
            3'b100:  res = XLEN'(sh[7:0]);
            3'b101:  res = XLEN'(sh[15:0]);
            3'b110:  res = XLEN'(sh[31:0]);
            default: res = sh;
        endcase
        return res;
    endfunction

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                    input logic [XLEN-1:0] new_v,
                                                    input logic [NB-1:0]   be);
        logic [XLEN-1:0] res;
        res = old_v;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign addr_al = req_addr & ALIGN_MASK;
    assign off_in  = req_addr[OFFW-1:0];
    assign size_in = req_funct3[1:0];

    // Port addresses are compared after alignment so a base that is not XLEN-aligned still decodes.
    for (genvar g = 0; g < NUM_OUTPORTS; g++) begin : g_port
        assign port_match[g] =
            (addr_al == ((XLEN'(OUTPORT_BASE) + XLEN'(g * NB)) & ALIGN_MASK));
    end

    always_comb begin
        f3_ok = 1'b1;
        case (req_funct3)
            3'b011, 3'b110: f3_ok = (XLEN == 64);
            3'b111:         f3_ok = 1'b0;
            default:        f3_ok = 1'b1;
        endcase

        misaligned = 1'b0;
        case (size_in)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase

        req_err  = !f3_ok || misaligned;
        port_hit = !req_err && (|port_match);

        be_in     = '1;
        wdata_rep = req_wdata;
        case (size_in)
            2'd0: begin
                be_in     = NB'(1) << off_in;
                wdata_rep = {NB{req_wdata[7:0]}};
            end
            2'd1: begin
                be_in     = NB'(3) << off_in;
                wdata_rep = {(NB/2){req_wdata[15:0]}};
            end
            2'd2: begin
                be_in     = NB'(4'hF) << off_in;
                wdata_rep = {(XLEN/32){req_wdata[31:0]}};
            end
            default: begin
                be_in     = '1;
                wdata_rep = req_wdata;
            end
        endcase

        port_rd = '0;
        for (int i = 0; i < NUM_OUTPORTS; i++) begin
            if (port_match[i]) port_rd = port_rd | outport_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            outport_q    <= '0;
            outport_wr_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            outport_q    <= outport_d;
            outport_wr_q <= outport_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = (req_err || port_hit) ? ST_RESP : ST_MEM;
            end
            ST_MEM: begin
                if (mem_ack) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        outport_d    = outport_q;
        outport_wr_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = off_in;
                    addr_d  = addr_al;
                    be_d    = be_in;
                    wdata_d = wdata_rep;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (port_hit) begin
                        if (req_we) begin
                            for (int i = 0; i < NUM_OUTPORTS; i++) begin
                                if (port_match[i]) begin
                                    outport_d[i]    = merge_bytes(outport_q[i], wdata_rep, be_in);
                                    outport_wr_d[i] = 1'b1;
                                end
                            end
                        end else begin
                            rdata_d = load_ext(port_rd, off_in, req_funct3);
                        end
                    end
                end
            end
            ST_MEM: begin
                if (mem_ack && !we_q) rdata_d = load_ext(mem_rdata, off_q, f3_q);
            end
            ST_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        mem_req    = (state_q == ST_MEM);
        mem_we     = (state_q == ST_MEM) && we_q;
        mem_be     = (state_q == ST_MEM) ? be_q : '0;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        outport    = outport_q;
        outport_wr = outport_wr_q;
    end

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed-vector bench for lsu_mmio (XLEN=32, two outports at 0xFFFC / 0x10000).
module tb_lsu_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [63:0] outport;
    logic [1:0]  outport_wr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mmio #(.XLEN(32), .NUM_OUTPORTS(2), .OUTPORT_BASE(32'h0000fffc)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .outport    (outport),
        .outport_wr (outport_wr)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          ack_dly;
        logic        mem;
        logic [3:0]  be;
        logic [31:0] wd_exp;
        logic [31:0] rdata;
        logic        err;
        logic [63:0] outp;
        logic [1:0]  wr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int id, input vec_t v);
        int lat;
        int exp_lat;
        @(negedge clk);
        chk($sformatf("v%0d req_ready idle", id), 64'(req_ready), 64'd1);
        chk($sformatf("v%0d resp_valid idle", id), 64'(resp_valid), 64'd0);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (v.mem) begin
            chk($sformatf("v%0d mem_addr", id), 64'(mem_addr), 64'(v.addr & 32'hFFFF_FFFC));
            chk($sformatf("v%0d mem_we", id), 64'(mem_we), 64'(v.we));
            if (v.we) chk($sformatf("v%0d mem_wdata", id), 64'(mem_wdata), 64'(v.wd_exp));
            while (!resp_valid && lat < 20) begin
                chk($sformatf("v%0d mem_req c%0d", id, lat), 64'(mem_req), 64'd1);
                chk($sformatf("v%0d mem_be c%0d", id, lat), 64'(mem_be), 64'(v.be));
                if (lat == v.ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.mdata;
                end
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 32'hA5A5_A5A5;
                lat++;
            end
            exp_lat = v.ack_dly + 1;
        end else begin
            chk($sformatf("v%0d no mem_req", id), 64'(mem_req), 64'd0);
            exp_lat = 1;
        end
        chk($sformatf("v%0d resp_valid", id), 64'(resp_valid), 64'd1);
        chk($sformatf("v%0d latency", id), 64'(lat), 64'(exp_lat));
        chk($sformatf("v%0d resp_rdata", id), 64'(resp_rdata), 64'(v.rdata));
        chk($sformatf("v%0d resp_err", id), 64'(resp_err), 64'(v.err));
        chk($sformatf("v%0d outport", id), outport, v.outp);
        chk($sformatf("v%0d outport_wr", id), 64'(outport_wr), 64'(v.wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         we  f3      addr           wdata          mdata         dly mem be       wd_exp         rdata          err outp                    wr
        tbl[0]  = '{0, 3'b000, 32'h0000_0101, 32'h0,         32'h1280_3456, 3, 1, 4'b0010, 32'h0,         32'h0000_0034, 0, 64'h0,                  2'b00};
        tbl[1]  = '{0, 3'b000, 32'h0000_0102, 32'h0,         32'h1280_3456, 1, 1, 4'b0100, 32'h0,         32'hFFFF_FF80, 0, 64'h0,                  2'b00};
        tbl[2]  = '{0, 3'b100, 32'h0000_0102, 32'h0,         32'h1280_3456, 2, 1, 4'b0100, 32'h0,         32'h0000_0080, 0, 64'h0,                  2'b00};
        tbl[3]  = '{1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,         0, 64'h0,                  2'b00};
        tbl[4]  = '{1, 3'b010, 32'h0000_FFFC, 32'hDEAD_BEEF, 32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         0, 64'h00000000_DEADBEEF, 2'b01};
        tbl[5]  = '{1, 3'b000, 32'h0000_FFFD, 32'h0000_0055, 32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         0, 64'h00000000_DEAD55EF, 2'b01};
        tbl[6]  = '{1, 3'b010, 32'h0001_0000, 32'h0000_1234, 32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         0, 64'h00001234_DEAD55EF, 2'b10};
        tbl[7]  = '{0, 3'b010, 32'h0001_0000, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'h0000_1234, 0, 64'h00001234_DEAD55EF, 2'b00};
        tbl[8]  = '{0, 3'b101, 32'h0000_FFFE, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'h0000_DEAD, 0, 64'h00001234_DEAD55EF, 2'b00};
        tbl[9]  = '{0, 3'b001, 32'h0000_FFFE, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'hFFFF_DEAD, 0, 64'h00001234_DEAD55EF, 2'b00};
        tbl[10] = '{0, 3'b001, 32'h0000_0003, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         1, 64'h00001234_DEAD55EF, 2'b00};
        tbl[11] = '{1, 3'b010, 32'h0000_0002, 32'h1111_1111, 32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         1, 64'h00001234_DEAD55EF, 2'b00};
        tbl[12] = '{0, 3'b111, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         1, 64'h00001234_DEAD55EF, 2'b00};
        tbl[13] = '{0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         1, 64'h00001234_DEAD55EF, 2'b00};
        tbl[14] = '{1, 3'b010, 32'h0000_FFFE, 32'h9999_9999, 32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         1, 64'h00001234_DEAD55EF, 2'b00};
        tbl[15] = '{1, 3'b010, 32'h0001_0004, 32'hCAFE_F00D, 32'h0,         1, 1, 4'b1111, 32'hCAFE_F00D, 32'h0,         0, 64'h00001234_DEAD55EF, 2'b00};
        tbl[16] = '{0, 3'b001, 32'h0000_0202, 32'h0,         32'h89AB_CDEF, 2, 1, 4'b1100, 32'h0,         32'hFFFF_89AB, 0, 64'h00001234_DEAD55EF, 2'b00};
        tbl[17] = '{1, 3'b000, 32'h0001_0003, 32'h0000_007F, 32'h0,         0, 0, 4'b0000, 32'h0,         32'h0,         0, 64'h7F001234_DEAD55EF, 2'b10};
        tbl[18] = '{0, 3'b000, 32'h0001_0003, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'h0000_007F, 0, 64'h7F001234_DEAD55EF, 2'b00};
        tbl[19] = '{0, 3'b000, 32'h0000_FFFF, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         32'hFFFF_FFDE, 0, 64'h7F001234_DEAD55EF, 2'b00};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_err", 64'(resp_err), 64'd0);
        chk("reset resp_rdata", 64'(resp_rdata), 64'd0);
        chk("reset mem_req", 64'(mem_req), 64'd0);
        chk("reset mem_be", 64'(mem_be), 64'd0);
        chk("reset outport", outport, 64'd0);
        chk("reset outport_wr", 64'(outport_wr), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) do_txn(i, tbl[i]);

        // Reset in the second MEM cycle, then a late ack that must be ignored.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mrst mem_req mem1", 64'(mem_req), 64'd1);
        @(negedge clk);
        chk("mrst mem_req mem2", 64'(mem_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        chk("mrst mem_req", 64'(mem_req), 64'd0);
        chk("mrst mem_be", 64'(mem_be), 64'd0);
        chk("mrst resp_valid", 64'(resp_valid), 64'd0);
        chk("mrst req_ready", 64'(req_ready), 64'd1);
        chk("mrst outport", outport, 64'd0);
        chk("mrst outport_wr", 64'(outport_wr), 64'd0);
        chk("mrst resp_rdata", 64'(resp_rdata), 64'd0);
        chk("mrst resp_err", 64'(resp_err), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mrst late ack resp_valid c%0d", c), 64'(resp_valid), 64'd0);
            chk($sformatf("mrst late ack mem_req c%0d", c), 64'(mem_req), 64'd0);
            @(negedge clk);
        end

        // Reset while the response of a port store is being presented.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_FFFC;
        req_wdata  = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rrst resp_valid", 64'(resp_valid), 64'd1);
        chk("rrst outport", outport, 64'h00000000_0BADF00D);
        chk("rrst outport_wr", 64'(outport_wr), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rrst resp_valid after", 64'(resp_valid), 64'd0);
        chk("rrst outport after", outport, 64'd0);
        chk("rrst outport_wr after", 64'(outport_wr), 64'd0);
        chk("rrst req_ready after", 64'(req_ready), 64'd1);

        // Normal operation resumes after reset.
        do_txn(100, tbl[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
